// File: rtl/bus_mem_if.sv
// bus_mem_if: CPU-side memory bus between a bus master and bus_mem.
// data_bus is one shared tristate net. Each side supplies a data/enable
// pair and the net resolves them here. The slave is listed first so that
// the responder's read data is what a reader sees if both sides drive.
interface bus_mem_if;
  logic        mem_ce;
  logic        mem_r;
  logic        mem_w;
  logic        mem_oe;
  logic [15:0] addr_bus;
  logic        mem_rdy;
  logic [7:0]  mst_data;
  logic        mst_drv;
  logic [7:0]  slv_data;
  logic        slv_drv;
  wire  [7:0]  data_bus;

  assign data_bus = slv_drv ? slv_data : (mst_drv ? mst_data : 8'hzz);

  modport master (
    output mem_ce, mem_r, mem_w, mem_oe, addr_bus, mst_data, mst_drv,
    input  mem_rdy, data_bus, slv_drv
  );

  modport slave (
    input  mem_ce, mem_r, mem_w, mem_oe, addr_bus, data_bus,
    output mem_rdy, slv_data, slv_drv
  );
endinterface

// File: rtl/bus_mem.sv
// bus_mem: byte RAM plus an LED output register on a CPU memory bus.
// Build option: define MEM_WAIT_EN to add an IDLE/BUSY/DONE wait-state
// FSM. Without it, mem_rdy is tied high and every qualifying edge is
// accepted.
module bus_mem #(
  parameter int          RAM_DEPTH   = 256,
  parameter logic [15:0] LED_ADDR    = 16'hFF00,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic     clk,
  input  logic     rst,
  bus_mem_if.slave bus,
  output logic [7:0] led
);
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [7:0]    r_ram [RAM_DEPTH];
  logic [7:0]    r_led;
  logic [7:0]    r_rdata;
  logic          r_rd_valid;

  logic          w_req;
  logic          w_accept;
  logic          w_rdy;
  logic          w_in_ram;
  logic          w_is_led;
  logic [AW-1:0] w_ram_idx;
  logic [7:0]    w_rd_byte;

  // A request needs chip enable and exactly one strobe. Nothing is
  // accepted while reset is held, so RAM cannot change during reset.
  assign w_req     = ~rst & bus.mem_ce & (bus.mem_r ^ bus.mem_w);

  // RAM decode is a plain range check: addresses above the RAM never wrap.
  assign w_in_ram  = (bus.addr_bus < 16'(RAM_DEPTH));
  assign w_is_led  = (bus.addr_bus == LED_ADDR);
  assign w_ram_idx = bus.addr_bus[AW-1:0];

`ifdef MEM_WAIT_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_rdy;

  // Only IDLE accepts. Requests seen in BUSY or DONE are dropped; the
  // CPU must present them again.
  assign w_accept = w_req & (r_state == IDLE);
  assign w_rdy    = r_rdy;

  // Wait-state FSM: BUSY lasts WAIT_CYCLES cycles, then DONE lasts one
  // cycle. mem_rdy is registered along with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdy   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= BUSY;
            r_cnt   <= 4'(WAIT_CYCLES - 1);
            r_rdy   <= 1'b0;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_rdy   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_rdy   <= 1'b1;
        end
      endcase
    end
  end
`else
  assign w_accept = w_req;
  assign w_rdy    = 1'b1;
`endif

  // Read mux: RAM byte, LED register, or zero for unmapped addresses.
  always_comb begin
    w_rd_byte = 8'h00;
    if (w_in_ram) begin
      w_rd_byte = r_ram[w_ram_idx];
    end else if (w_is_led) begin
      w_rd_byte = r_led;
    end
  end

  // RAM array has no reset. Writes commit on the accept edge, so a later
  // abort or reset cannot undo them.
  always_ff @(posedge clk) begin
    if (w_accept && bus.mem_w && w_in_ram) begin
      r_ram[w_ram_idx] <= bus.data_bus;
    end
  end

  // LED register and read-data capture. A write invalidates held read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led      <= 8'h00;
      r_rdata    <= 8'h00;
      r_rd_valid <= 1'b0;
    end else if (w_accept) begin
      if (bus.mem_w) begin
        r_rd_valid <= 1'b0;
        if (w_is_led) begin
          r_led <= bus.data_bus;
        end
      end else begin
        r_rdata    <= w_rd_byte;
        r_rd_valid <= 1'b1;
      end
    end
  end

  // Drive the bus only when the CPU asks for it and the data is complete.
  assign bus.slv_drv  = bus.mem_ce & bus.mem_oe & r_rd_valid & w_rdy;
  assign bus.slv_data = r_rdata;
  assign bus.mem_rdy  = w_rdy;
  assign led          = r_led;
endmodule
